abend_cpu: RTL and testbench
============================

Name: abend_cpu

Overview:
- Single-cycle 32-bit MIPS-subset processor with precise exceptions and one external interrupt line.
- Contains its own instruction ROM, data RAM, 32x32 register file and a minimal CP0 block: Status, Cause and EPC.
- This is the top-level CPU of the exception/interrupt design. The only external pins are clock, reset and the interrupt handshake.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in words, word-addressed by PC[7:2].
- DMEM_WORDS, 32, data RAM depth in words, word-addressed by addr[6:2].
- IMEM_FILE, "prog.hex", hex image loaded into the ROM at elaboration.
- HANDLER_ADDR, 32'h00000008, the common exception/interrupt vector.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Clrn  input  1  reset, synchronous, active-high.
- Intr  input  1  external interrupt request, level-sensitive, synchronous to Clk.
- Inta  output  1  interrupt acknowledge, registered.

Behaviour:
- Reset: when Clrn=1 at a rising edge, all of the following are cleared:
  - PC <= 0
  - all 32 GPRs <= 0
  - Status <= 0, Cause <= 0, EPC <= 0
  - Inta <= 0
  - Data RAM is not cleared.
  - Reset has priority over every other event, including one in the middle of an interrupt entry.
- Instruction execution: one instruction completes per cycle. $0 always reads 0 and writes to it are ignored.
- Instruction set:
  - R-type: add, sub, and, or, slt, jr, syscall (funct 0x0C).
  - I-type: addi, andi, ori, lui, lw, sw, beq, bne.
  - J-type: j.
  - COP0 (opcode 0x10): mfc0 (rs=0), mtc0 (rs=4), eret (funct 0x18).
  - Branch target = PC+4+(signext(imm)<<2). Jump target = {PC+4[31:28], target, 2'b00}.
- CP0 registers:
  - Status (reg 12): bit0 = IE, bit1 = saved IE. Other bits read 0.
  - Cause (reg 13): bits[6:2] = ExcCode. Other bits read 0.
  - EPC (reg 14).
  - mfc0 and mtc0 to any other CP0 register number read 0 / write nothing.
- Event priority, evaluated each cycle before the instruction commits:
  1. Interrupt: Intr=1 and Status.IE=1. The current instruction is not executed; EPC <= PC; ExcCode = 0.
  2. Reserved instruction (any unlisted opcode/funct): no register/memory write; EPC <= PC; ExcCode = 10.
  3. Arithmetic overflow on add, sub or addi (signed): destination not written; EPC <= PC; ExcCode = 12.
  4. syscall: EPC <= PC+4; ExcCode = 8.
- On taking any event:
  - Status[1] <= Status[0], Status[0] <= 0.
  - Cause.ExcCode is updated.
  - PC <= HANDLER_ADDR.
  - Inta <= 1 at the same edge for an interrupt; Inta stays 1 for exactly one cycle and then returns to 0.
  - Inta is never asserted for synchronous exceptions.
- eret: PC <= EPC; Status[0] <= Status[1]. Interrupts become acceptable again from the next cycle.
- Holding Intr high:
  - Because IE is cleared on entry, a held Intr does not re-enter the handler.
  - It is re-accepted only after an eret or mtc0 sets IE, if Intr is still 1.
- Memory accesses: lw/sw use word addresses. Out-of-range addresses wrap modulo depth. sw writes at the rising edge.
- PC wraps modulo 2^32. ROM reads use only the index bits.

Test Plan:
- Reset: hold Clrn=1 for 1 cycle, then release.
  - Required: PC=0, Inta=0, Status=Cause=EPC=0.
  - The first instruction executes in the cycle after release.
- Arithmetic program: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0($0); lw $4,0($0).
  - Required: $3=12, $4=12, mem[0]=12.
- Overflow: lui $1,0x7FFF; ori $1,$1,0xFFFF; addi $2,$1,1.
  - Required: $2 unchanged (0), EPC = address of the addi, ExcCode=12, PC=0x08 on the next cycle, Inta=0.
- Interrupt: enable IE with mtc0, then drive Intr=1 for 16 cycles (Intr rises 2 cycles after reset release).
  - Required: Inta pulses high for exactly 1 cycle.
  - Required: EPC = the PC that was not executed, ExcCode=0, PC=0x08.
  - Required: no second entry while IE=0.
- eret: the handler executes eret.
  - Required: PC = EPC and Status.IE restored to 1.
  - Required: if Intr is still high, it is accepted again on the next cycle, with a second Inta pulse.
- syscall and reserved opcode 0x3F.
  - Required for syscall: EPC=PC+4, ExcCode=8.
  - Required for reserved opcode: EPC=PC, ExcCode=10.
  - Both: no GPR change.

Source files
------------

// File: rtl/abend_cpu.sv
// -----------------------------------------------------------------------------
// abend_cpu
//   Single-cycle 32-bit MIPS-subset core with precise exceptions and a single
//   level-sensitive external interrupt. Instruction ROM, data RAM, a 32x32
//   register file and a minimal CP0 (Status, Cause, EPC) live inside.
//
//   Ports
//     Clk   in   system clock, every state update on the rising edge
//     Clrn  in   synchronous active-high reset (clears PC, GPRs, CP0, Inta)
//     Intr  in   interrupt request, level-sensitive, synchronous to Clk
//     Inta  out  interrupt acknowledge, registered, one-cycle pulse
//
//   Interrupt handshake: Intr acts as "valid" and Status.IE acts as "ready".
//   The request is taken on the rising edge where Intr=1 and IE=1; at that
//   same edge Inta goes high for exactly one cycle. Taking the request clears
//   IE, so a held Intr is not taken again until eret or mtc0 sets IE.
//
//   The ROM is never written by the core; its image (named by IMEM_FILE) is
//   supplied by the surrounding environment at elaboration.
// -----------------------------------------------------------------------------
module abend_cpu #(
   parameter int unsigned IMEM_WORDS   = 64,
   parameter int unsigned DMEM_WORDS   = 32,
   parameter              IMEM_FILE    = "prog.hex",
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0008
) (
   input  logic Clk,
   input  logic Clrn,
   input  logic Intr,
   output logic Inta
);

   localparam int unsigned IA_W = $clog2(IMEM_WORDS);
   localparam int unsigned DA_W = $clog2(DMEM_WORDS);
   localparam int unsigned imem_file_unused = $bits(IMEM_FILE);

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_COP0  = 6'h10;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] F_JR      = 6'h08;
   localparam logic [5:0] F_SYSCALL = 6'h0C;
   localparam logic [5:0] F_ADD     = 6'h20;
   localparam logic [5:0] F_SUB     = 6'h22;
   localparam logic [5:0] F_AND     = 6'h24;
   localparam logic [5:0] F_OR      = 6'h25;
   localparam logic [5:0] F_SLT     = 6'h2A;
   localparam logic [5:0] F_ERET    = 6'h18;

   // CP0 register numbers and exception codes
   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;
   localparam logic [4:0] EXC_INT    = 5'd0;
   localparam logic [4:0] EXC_SYS    = 5'd8;
   localparam logic [4:0] EXC_RI     = 5'd10;
   localparam logic [4:0] EXC_OV     = 5'd12;

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   logic [31:0] rom   [IMEM_WORDS];
   logic [31:0] dmem  [DMEM_WORDS];
   logic [31:0] gpr_q [32];

   logic [31:0] pc_q, pc_d;
   logic [1:0]  status_q, status_d;     // [0]=IE, [1]=saved IE
   logic [4:0]  exc_code_q, exc_code_d; // Cause[6:2]
   logic [31:0] epc_q, epc_d;
   logic        inta_q, inta_d;

   // ---------------------------------------------------------------------------
   // Fetch and field extraction
   // ---------------------------------------------------------------------------
   logic [31:0] instr;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [25:0] target;

   assign instr  = rom[pc_q[IA_W+1:2]];
   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign shamt  = instr[10:6];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];
   assign target = instr[25:0];

   // gpr_q[0] is cleared on reset and never written, so $0 reads as zero.
   logic [31:0] rs_val, rt_val;
   assign rs_val = gpr_q[rs];
   assign rt_val = gpr_q[rt];

   logic [31:0] pc_plus4, imm_sext, imm_zext, br_target, j_target;
   assign pc_plus4  = pc_q + 32'd4;
   assign imm_sext  = {{16{imm[15]}}, imm};
   assign imm_zext  = {16'h0000, imm};
   assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
   assign j_target  = {pc_plus4[31:28], target, 2'b00};

   // ---------------------------------------------------------------------------
   // ALU results and signed overflow detection
   // ---------------------------------------------------------------------------
   logic [31:0] add_res, sub_res, addi_res, slt_res;
   logic        add_ovf, sub_ovf, addi_ovf;

   assign add_res  = rs_val + rt_val;
   assign sub_res  = rs_val - rt_val;
   assign addi_res = rs_val + imm_sext;
   assign slt_res  = {31'b0, ($signed(rs_val) < $signed(rt_val))};

   // Overflow when both operands (after negation for sub) share a sign that
   // the result does not.
   assign add_ovf  = (rs_val[31] == rt_val[31])   && (add_res[31]  != rs_val[31]);
   assign sub_ovf  = (rs_val[31] != rt_val[31])   && (sub_res[31]  != rs_val[31]);
   assign addi_ovf = (rs_val[31] == imm_sext[31]) && (addi_res[31] != rs_val[31]);

   // ---------------------------------------------------------------------------
   // Data memory address (word addressed, wraps modulo depth)
   // ---------------------------------------------------------------------------
   logic [31:0]     mem_addr;
   logic [DA_W-1:0] dmem_idx;
   logic [31:0]     dmem_rdata;

   assign mem_addr   = rs_val + imm_sext;
   assign dmem_idx   = mem_addr[DA_W+1:2];
   assign dmem_rdata = dmem[dmem_idx];

   // ---------------------------------------------------------------------------
   // CP0 read view: unimplemented bits and registers read as zero
   // ---------------------------------------------------------------------------
   logic [31:0] cp0_rdata;

   always_comb begin
      cp0_rdata = 32'h0;
      case (rd)
         CP0_STATUS: cp0_rdata = {30'b0, status_q};
         CP0_CAUSE:  cp0_rdata = {25'b0, exc_code_q, 2'b00};
         CP0_EPC:    cp0_rdata = epc_q;
         default:    cp0_rdata = 32'h0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Decode: what the instruction would do if no event pre-empts it
   // ---------------------------------------------------------------------------
   logic        legal;
   logic        gpr_we;
   logic [4:0]  gpr_waddr;
   logic [31:0] gpr_wdata;
   logic        dmem_we;
   logic [31:0] next_pc;
   logic        ovf;
   logic        is_sys;
   logic        is_eret;
   logic        cp0_we;

   always_comb begin
      legal     = 1'b0;
      gpr_we    = 1'b0;
      gpr_waddr = rt;
      gpr_wdata = 32'h0;
      dmem_we   = 1'b0;
      next_pc   = pc_plus4;
      ovf       = 1'b0;
      is_sys    = 1'b0;
      is_eret   = 1'b0;
      cp0_we    = 1'b0;

      case (opcode)
         OP_RTYPE: begin
            gpr_waddr = rd;
            case (funct)
               F_ADD: begin
                  legal = 1'b1; gpr_we = 1'b1; gpr_wdata = add_res; ovf = add_ovf;
               end
               F_SUB: begin
                  legal = 1'b1; gpr_we = 1'b1; gpr_wdata = sub_res; ovf = sub_ovf;
               end
               F_AND: begin
                  legal = 1'b1; gpr_we = 1'b1; gpr_wdata = rs_val & rt_val;
               end
               F_OR: begin
                  legal = 1'b1; gpr_we = 1'b1; gpr_wdata = rs_val | rt_val;
               end
               F_SLT: begin
                  legal = 1'b1; gpr_we = 1'b1; gpr_wdata = slt_res;
               end
               F_JR: begin
                  legal = 1'b1; next_pc = rs_val;
               end
               F_SYSCALL: begin
                  legal = 1'b1; is_sys = 1'b1;
               end
               default: legal = 1'b0;
            endcase
         end
         OP_J: begin
            legal = 1'b1; next_pc = j_target;
         end
         OP_BEQ: begin
            legal = 1'b1;
            if (rs_val == rt_val) next_pc = br_target;
         end
         OP_BNE: begin
            legal = 1'b1;
            if (rs_val != rt_val) next_pc = br_target;
         end
         OP_ADDI: begin
            legal = 1'b1; gpr_we = 1'b1; gpr_wdata = addi_res; ovf = addi_ovf;
         end
         OP_ANDI: begin
            legal = 1'b1; gpr_we = 1'b1; gpr_wdata = rs_val & imm_zext;
         end
         OP_ORI: begin
            legal = 1'b1; gpr_we = 1'b1; gpr_wdata = rs_val | imm_zext;
         end
         OP_LUI: begin
            legal = 1'b1; gpr_we = 1'b1; gpr_wdata = {imm, 16'h0000};
         end
         OP_LW: begin
            legal = 1'b1; gpr_we = 1'b1; gpr_wdata = dmem_rdata;
         end
         OP_SW: begin
            legal = 1'b1; dmem_we = 1'b1;
         end
         OP_COP0: begin
            if (rs == 5'd0) begin
               legal = 1'b1; gpr_we = 1'b1; gpr_wdata = cp0_rdata;
            end else if (rs == 5'd4) begin
               legal = 1'b1; cp0_we = 1'b1;
            end else if (rs == 5'h10 && funct == F_ERET) begin
               legal = 1'b1; is_eret = 1'b1; next_pc = epc_q;
            end
         end
         default: legal = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Event arbitration and commit. Any event suppresses every architectural
   // write of the current instruction; only syscall counts as completed, so
   // it alone saves PC+4.
   // ---------------------------------------------------------------------------
   logic take_int, take_exc;
   logic gpr_commit, dmem_commit;

   assign take_int = Intr & status_q[0];
   assign take_exc = take_int | ~legal | ovf | is_sys;

   always_comb begin
      pc_d        = next_pc;
      status_d    = status_q;
      exc_code_d  = exc_code_q;
      epc_d       = epc_q;
      inta_d      = 1'b0;
      gpr_commit  = gpr_we & (gpr_waddr != 5'd0);
      dmem_commit = dmem_we;

      if (take_exc) begin
         pc_d        = HANDLER_ADDR;
         status_d    = {status_q[0], 1'b0};
         inta_d      = take_int;
         gpr_commit  = 1'b0;
         dmem_commit = 1'b0;
         epc_d       = pc_q;
         if (take_int) begin
            exc_code_d = EXC_INT;
         end else if (!legal) begin
            exc_code_d = EXC_RI;
         end else if (ovf) begin
            exc_code_d = EXC_OV;
         end else begin
            exc_code_d = EXC_SYS;
            epc_d      = pc_plus4;
         end
      end else begin
         if (is_eret) status_d[0] = status_q[1];
         if (cp0_we) begin
            case (rd)
               CP0_STATUS: status_d   = rt_val[1:0];
               CP0_CAUSE:  exc_code_d = rt_val[6:2];
               CP0_EPC:    epc_d      = rt_val;
               default:    ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Clrn) begin
         pc_q       <= 32'h0;
         status_q   <= 2'b00;
         exc_code_q <= 5'd0;
         epc_q      <= 32'h0;
         inta_q     <= 1'b0;
         for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
      end else begin
         pc_q       <= pc_d;
         status_q   <= status_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
         inta_q     <= inta_d;
         if (gpr_commit) gpr_q[gpr_waddr] <= gpr_wdata;
      end
   end

   // Data RAM keeps its contents across reset, but a store never lands while
   // reset is asserted.
   always_ff @(posedge Clk) begin
      if (!Clrn && dmem_commit) dmem[dmem_idx] <= rt_val;
   end

   assign Inta = inta_q;

   // Address bits that the word-indexed memory and the decode do not need.
   logic unused_bits;
   assign unused_bits = ^{shamt, mem_addr[1:0], mem_addr[31:DA_W+2]};

endmodule

// File: tb/tb_abend_cpu.sv
// -----------------------------------------------------------------------------
// tb_abend_cpu
//   Directed bench for abend_cpu. Programs are written into the core's ROM
//   through the hierarchy, each followed by a reset; architectural state is
//   observed through the hierarchy half a cycle after each rising edge.
// -----------------------------------------------------------------------------
module tb_abend_cpu;

   logic clk = 1'b0;
   logic clrn;
   logic intr;
   logic inta;

   int n_tests = 0;
   int n_fail  = 0;
   int inta_high = 0;
   int inta_rise = 0;
   logic inta_prev = 1'b0;

   localparam logic [31:0] SPIN = 32'h1000_FFFF; // beq $0,$0,-1
   localparam logic [31:0] ERET = 32'h4200_0018;

   abend_cpu dut (
      .Clk  (clk),
      .Clrn (clrn),
      .Intr (intr),
      .Inta (inta)
   );

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;

   // ---------------------------------------------------------- encoders
   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] t);
      return {6'h02, t};
   endfunction

   function automatic logic [31:0] enc_c0(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
      return {6'h10, rs, rt, rd, 11'h000};
   endfunction

   // ---------------------------------------------------------- driver tasks
   task automatic fill_rom();
      for (int i = 0; i < 64; i++) dut.rom[i] = SPIN;
   endtask

   // Advance n cycles; sample at the falling edge and track Inta pulses.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (inta === 1'b1) inta_high++;
         if (inta === 1'b1 && inta_prev !== 1'b1) inta_rise++;
         inta_prev = inta;
      end
   endtask

   task automatic do_reset();
      clrn = 1'b1;
      tick(1);
      clrn = 1'b0;
   endtask

   // ---------------------------------------------------------- checker
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pc"},     dut.pc_q, 32'h0);
      chk({tag, "_inta"},   {31'b0, inta}, 32'h0);
      chk({tag, "_status"}, {30'b0, dut.status_q}, 32'h0);
      chk({tag, "_cause"},  {27'b0, dut.exc_code_q}, 32'h0);
      chk({tag, "_epc"},    dut.epc_q, 32'h0);
   endtask

   // ---------------------------------------------------------- stimulus
   initial begin
      clrn = 1'b1;
      intr = 1'b0;

      // ===== Test 1: arithmetic, logic, branches, jumps, memory =====
      fill_rom();
      dut.rom[0]  = enc_i(6'h08, 0, 1, 16'd5);        // addi $1,$0,5
      dut.rom[1]  = enc_i(6'h08, 0, 2, 16'd7);        // addi $2,$0,7
      dut.rom[2]  = enc_r(1, 2, 3, 6'h20);            // add  $3,$1,$2
      dut.rom[3]  = enc_i(6'h2B, 0, 3, 16'd0);        // sw   $3,0($0)
      dut.rom[4]  = enc_i(6'h23, 0, 4, 16'd0);        // lw   $4,0($0)
      dut.rom[5]  = enc_r(2, 1, 5, 6'h22);            // sub  $5,$2,$1
      dut.rom[6]  = enc_r(1, 2, 6, 6'h24);            // and  $6,$1,$2
      dut.rom[7]  = enc_r(1, 2, 7, 6'h25);            // or   $7,$1,$2
      dut.rom[8]  = enc_r(1, 2, 8, 6'h2A);            // slt  $8,$1,$2
      dut.rom[9]  = enc_i(6'h08, 0, 9, 16'hFFFF);     // addi $9,$0,-1
      dut.rom[10] = enc_r(9, 1, 10, 6'h2A);           // slt  $10,$9,$1
      dut.rom[11] = enc_i(6'h0C, 9, 11, 16'h00F0);    // andi $11,$9,0xF0
      dut.rom[12] = enc_i(6'h0D, 0, 12, 16'h8001);    // ori  $12,$0,0x8001
      dut.rom[13] = enc_i(6'h0F, 0, 13, 16'h1234);    // lui  $13,0x1234
      dut.rom[14] = enc_i(6'h04, 1, 2, 16'd5);        // beq  $1,$2,+5 (not taken)
      dut.rom[15] = enc_i(6'h05, 1, 2, 16'd1);        // bne  $1,$2,+1 (taken)
      dut.rom[16] = enc_i(6'h08, 0, 14, 16'd99);      // skipped
      dut.rom[17] = enc_j(26'd20);                    // j 0x50
      dut.rom[18] = enc_i(6'h08, 0, 14, 16'd98);      // skipped
      dut.rom[19] = enc_i(6'h08, 0, 14, 16'd97);      // skipped
      dut.rom[20] = enc_i(6'h08, 0, 15, 16'h0060);    // addi $15,$0,0x60
      dut.rom[21] = enc_r(15, 0, 0, 6'h08);           // jr   $15
      dut.rom[22] = enc_i(6'h08, 0, 14, 16'd96);      // skipped
      dut.rom[23] = enc_i(6'h08, 0, 14, 16'd95);      // skipped
      dut.rom[24] = enc_i(6'h08, 0, 0, 16'd1);        // addi $0,$0,1
      dut.rom[25] = enc_i(6'h2B, 3, 1, 16'd4);        // sw   $1,4($3) -> mem[4]
      dut.rom[26] = enc_i(6'h23, 0, 16, 16'h0080);    // lw   $16,128($0) wraps to mem[0]
      do_reset();
      chk_reset("rst1");
      chk("rst1_gpr1", dut.gpr_q[1], 32'h0);

      tick(22);
      chk("t1_pc",   dut.pc_q,      32'h0000_006C);
      chk("t1_r1",   dut.gpr_q[1],  32'd5);
      chk("t1_r2",   dut.gpr_q[2],  32'd7);
      chk("t1_add",  dut.gpr_q[3],  32'd12);
      chk("t1_lw",   dut.gpr_q[4],  32'd12);
      chk("t1_mem0", dut.dmem[0],   32'd12);
      chk("t1_sub",  dut.gpr_q[5],  32'd2);
      chk("t1_and",  dut.gpr_q[6],  32'd5);
      chk("t1_or",   dut.gpr_q[7],  32'd7);
      chk("t1_slt",  dut.gpr_q[8],  32'd1);
      chk("t1_neg",  dut.gpr_q[9],  32'hFFFF_FFFF);
      chk("t1_slts", dut.gpr_q[10], 32'd1);
      chk("t1_andi", dut.gpr_q[11], 32'h0000_00F0);
      chk("t1_ori",  dut.gpr_q[12], 32'h0000_8001);
      chk("t1_lui",  dut.gpr_q[13], 32'h1234_0000);
      chk("t1_skip", dut.gpr_q[14], 32'h0);
      chk("t1_jr",   dut.gpr_q[15], 32'h0000_0060);
      chk("t1_r0",   dut.gpr_q[0],  32'h0);
      chk("t1_mem4", dut.dmem[4],   32'd5);
      chk("t1_wrap", dut.gpr_q[16], 32'd12);
      tick(3);
      chk("t1_spin", dut.pc_q, 32'h0000_006C);

      // ===== Test 2: addi overflow =====
      fill_rom();
      dut.rom[0] = enc_j(26'd4);
      dut.rom[4] = enc_i(6'h0F, 0, 1, 16'h7FFF);      // lui  $1,0x7FFF
      dut.rom[5] = enc_i(6'h0D, 1, 1, 16'hFFFF);      // ori  $1,$1,0xFFFF
      dut.rom[6] = enc_i(6'h08, 1, 2, 16'd1);         // addi $2,$1,1 -> overflow
      do_reset();
      chk_reset("rst2");
      chk("rst2_gpr3", dut.gpr_q[3], 32'h0);
      chk("rst2_mem0_kept", dut.dmem[0], 32'd12);
      tick(3);
      chk("t2_pre_pc", dut.pc_q,     32'h0000_0018);
      chk("t2_r1",     dut.gpr_q[1], 32'h7FFF_FFFF);
      tick(1);
      chk("t2_pc",     dut.pc_q,     32'h0000_0008);
      chk("t2_epc",    dut.epc_q,    32'h0000_0018);
      chk("t2_code",   {27'b0, dut.exc_code_q}, 32'd12);
      chk("t2_r2",     dut.gpr_q[2], 32'h0);
      chk("t2_inta",   {31'b0, inta}, 32'h0);
      tick(1);
      chk("t2_handler", dut.pc_q, 32'h0000_0008);

      // ===== Test 3: interrupt entry, held Intr, eret, re-entry =====
      fill_rom();
      dut.rom[0]  = enc_j(26'd4);
      dut.rom[2]  = enc_j(26'd10);                    // vector -> handler body
      dut.rom[4]  = enc_i(6'h08, 0, 1, 16'd1);        // addi $1,$0,1
      dut.rom[5]  = enc_c0(5'd4, 1, 12);              // mtc0 $1,Status
      dut.rom[6]  = enc_i(6'h08, 2, 2, 16'd1);        // addi $2,$2,1
      dut.rom[7]  = enc_j(26'd6);                     // j 0x18
      dut.rom[10] = enc_c0(5'd0, 4, 14);              // mfc0 $4,EPC
      dut.rom[11] = enc_c0(5'd0, 5, 12);              // mfc0 $5,Status
      dut.rom[12] = enc_i(6'h08, 3, 3, 16'd1);        // addi $3,$3,1
      dut.rom[13] = ERET;
      do_reset();
      chk_reset("rst3");
      inta_high = 0;
      inta_rise = 0;
      tick(2);
      chk("t3_pc_n2", dut.pc_q, 32'h0000_0014);
      intr = 1'b1;
      tick(1);
      chk("t3_ie_set",  {30'b0, dut.status_q}, 32'h1);
      chk("t3_no_int",  {31'b0, inta}, 32'h0);
      tick(1);
      chk("t3_inta",    {31'b0, inta}, 32'h1);
      chk("t3_pc",      dut.pc_q,  32'h0000_0008);
      chk("t3_epc",     dut.epc_q, 32'h0000_0018);
      chk("t3_code",    {27'b0, dut.exc_code_q}, 32'h0);
      chk("t3_status",  {30'b0, dut.status_q}, 32'h2);
      chk("t3_skipped", dut.gpr_q[2], 32'h0);
      tick(1);
      chk("t3_inta_off", {31'b0, inta}, 32'h0);
      tick(3);
      chk("t3_hpc",    dut.pc_q,     32'h0000_0034);
      chk("t3_mfc0e",  dut.gpr_q[4], 32'h0000_0018);
      chk("t3_mfc0s",  dut.gpr_q[5], 32'h2);
      chk("t3_r3",     dut.gpr_q[3], 32'd1);
      chk("t3_one_pulse", inta_high, 1);
      tick(1);
      chk("t3_eret_pc", dut.pc_q, 32'h0000_0018);
      chk("t3_eret_ie", {30'b0, dut.status_q}, 32'h3);
      tick(1);
      chk("t3_reinta",  {31'b0, inta}, 32'h1);
      chk("t3_repc",    dut.pc_q, 32'h0000_0008);
      chk("t3_restat",  {30'b0, dut.status_q}, 32'h2);
      tick(8);
      intr = 1'b0;
      tick(6);
      chk("t3_pulses",  inta_high, 3);
      chk("t3_rises",   inta_rise, 3);
      chk("t3_r3_end",  dut.gpr_q[3], 32'd3);
      chk("t3_r2_end",  dut.gpr_q[2], 32'd2);
      chk("t3_pc_end",  dut.pc_q, 32'h0000_001C);
      chk("t3_st_end",  {30'b0, dut.status_q}, 32'h3);

      // Reset and a pending interrupt on the same edge: reset wins.
      intr = 1'b1;
      clrn = 1'b1;
      tick(1);
      chk_reset("rst_int");
      chk("rst_int_r2", dut.gpr_q[2], 32'h0);
      clrn = 1'b0;
      intr = 1'b0;

      // ===== Test 4: syscall =====
      fill_rom();
      dut.rom[0] = enc_j(26'd4);
      dut.rom[4] = enc_i(6'h08, 0, 1, 16'd3);         // addi $1,$0,3
      dut.rom[5] = enc_r(0, 0, 0, 6'h0C);             // syscall
      do_reset();
      chk_reset("rst4");
      tick(3);
      chk("t4_pc",   dut.pc_q,  32'h0000_0008);
      chk("t4_epc",  dut.epc_q, 32'h0000_0018);
      chk("t4_code", {27'b0, dut.exc_code_q}, 32'd8);
      chk("t4_r1",   dut.gpr_q[1], 32'd3);
      chk("t4_inta", {31'b0, inta}, 32'h0);

      // ===== Test 5: reserved opcode 0x3F =====
      dut.rom[5] = 32'hFC22_0000;
      do_reset();
      chk_reset("rst5");
      tick(3);
      chk("t5_pc",   dut.pc_q,  32'h0000_0008);
      chk("t5_epc",  dut.epc_q, 32'h0000_0014);
      chk("t5_code", {27'b0, dut.exc_code_q}, 32'd10);
      chk("t5_r2",   dut.gpr_q[2], 32'h0);
      chk("t5_r1",   dut.gpr_q[1], 32'd3);
      chk("t5_inta", {31'b0, inta}, 32'h0);

      // ---------------------------------------------------------- report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
